// File: rtl/sensor_scan.sv
// Multi-channel sensor synchroniser/debouncer that streams an ASCII snapshot frame over valid/ready.
// Optional macro SENSOR_SCAN_AUTO_EN: also start a frame whenever any debounced state changes.
module sensor_scan #(
    parameter int NUM_CH         = 4,
    parameter int DEB_CYCLES     = 8,
    parameter int APPEND_NEWLINE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sensor_in,
    input  logic              sample_en,
    output logic [NUM_CH-1:0] sensor_state,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [IW-1:0] IDX_TOP  = IW'(NUM_CH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_CR   = 2'd2;
    localparam logic [1:0] S_LF   = 2'd3;

    logic [NUM_CH-1:0] sync1, sync2, snap, deb_flip;
    logic [CW-1:0]     cnt [NUM_CH];
    logic [IW-1:0]     idx;
    logic [1:0]        state;
    logic              req, hs;

    // Synchroniser and per-channel debounce
    always_comb begin
        deb_flip = '0;
        for (int i = 0; i < NUM_CH; i++)
            deb_flip[i] = (sync2[i] != sensor_state[i]) && (cnt[i] == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            sensor_state <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2[i] == sensor_state[i]) begin
                    cnt[i] <= '0;
                end else if (deb_flip[i]) begin
                    sensor_state[i] <= sync2[i];
                    cnt[i]          <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef SENSOR_SCAN_AUTO_EN
    logic chg_p1, pend;

    // Change-detect request lands the cycle after sensor_state moves; busy requests fold into pend
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_p1 <= 1'b0;
            pend   <= 1'b0;
        end else begin
            chg_p1 <= |deb_flip;
            if (state == S_IDLE)
                pend <= 1'b0;
            else if (chg_p1)
                pend <= 1'b1;
        end
    end

    assign req = sample_en | chg_p1 | pend;
`else
    assign req = sample_en;
`endif

    assign busy     = (state != S_IDLE);
    assign tx_valid = (state != S_IDLE);
    assign hs       = tx_valid && tx_ready;

    // Frame FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            snap    <= '0;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= (state != S_IDLE) && sample_en;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        snap  <= sensor_state;
                        idx   <= IDX_TOP;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        if (idx == '0)
                            state <= (APPEND_NEWLINE != 0) ? S_CR : S_IDLE;
                        else
                            idx <= idx - 1'b1;
                    end
                end
                S_CR:    if (hs) state <= S_LF;
                S_LF:    if (hs) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (state)
            S_SEND:  tx_data = snap[idx] ? 8'h31 : 8'h30;
            S_CR:    tx_data = 8'h0D;
            S_LF:    tx_data = 8'h0A;
            default: tx_data = 8'h00;
        endcase
    end

endmodule
